pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Sequences the three-output system PLL (50 / 25 / 6.25 MHz) from power-up to a usable state. It drives the PLL reset, synchronises and debounces the PLL lock flag, and releases per-clock-domain reset requests in a fixed staggered order. It detects lock loss, retries with a timeout and a bounded retry count, and raises a sticky failure flag if the PLL never locks. It sits at the top level between the PLL instance and the core's reset distribution, and runs on the PLL reference clock.

Parameters:
PLL_RST_CYCLES, 16, number of cycles pll_rst is held high per reset attempt (>=1)
LOCK_STABLE, 1024, consecutive cycles the synchronised lock must stay high before domain release (>=1)
LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK before a retry (>=2)
STAGGER, 8, cycles between successive domain reset releases (>=1)
MAX_RETRIES, 4, timeout retries allowed before entering FAIL (>=1)
NUM_DOM, 3, number of clock-domain reset outputs (index 0 = fastest clock)

Ports:
refclk  in  1  reference clock, 50 MHz; all logic is on this clock
rst_n  in  1  synchronous, active-low reset
pll_locked  in  1  PLL lock flag, asynchronous to refclk
force_relock  in  1  single-cycle request to restart the full sequence
pll_rst  out  1  active-high reset to the PLL
dom_rst  out  NUM_DOM  active-high reset request per clock domain; bit i corresponds to outclk_i
ready  out  1  high when all domains are released and the PLL is locked
fail  out  1  sticky flag: retries exhausted
retries  out  3  count of timeout retries in the current attempt

Behaviour:
- Reset (rst_n=0 at a refclk edge):
  - state=RESET_PLL, pll_rst=1, dom_rst=all 1, ready=0, fail=0, retries=0.
  - All internal counters and both sync flops are cleared.
- Lock input: pll_locked passes through a 2-flop synchroniser to give lock_s (2-cycle latency). Only lock_s is used internally.
- All outputs are registered and reflect the state in the same cycle the state is entered.
- Counter widths are $clog2(max(param)+1). The counter clears on every state entry.
- RESET_PLL:
  - pll_rst=1, dom_rst=all 1, ready=0.
  - After exactly PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, dom_rst=all 1.
  - If lock_s=1, go to STABLE.
  - Otherwise the counter increments. When it reaches LOCK_TIMEOUT-1, retries increments; then go to FAIL if the new value equals MAX_RETRIES, else go to RESET_PLL.
- STABLE:
  - dom_rst=all 1.
  - If lock_s=0, go to WAIT_LOCK; the timeout restarts and retries is unchanged.
  - After LOCK_STABLE consecutive high cycles, go to RELEASE.
- RELEASE:
  - dom_rst[0] clears on entry. dom_rst[i] clears STAGGER cycles after dom_rst[i-1].
  - STAGGER cycles after the last bit clears, go to RUN.
  - If lock_s=0 at any point, set dom_rst=all 1 on the next edge and go to RESET_PLL.
- RUN:
  - ready=1, dom_rst=0, retries cleared to 0.
  - If lock_s=0, then on the next edge: ready=0, dom_rst=all 1, state=RESET_PLL.
- FAIL:
  - pll_rst=0, dom_rst=all 1, ready=0, fail=1.
  - Stays in FAIL until rst_n=0 or force_relock=1.
- force_relock=1 in any state except RESET_PLL:
  - Next state is RESET_PLL; retries=0, fail=0, dom_rst=all 1, ready=0.
  - force_relock has priority over lock loss, timeout and stable completion in the same cycle.
  - force_relock=1 while already in RESET_PLL restarts the PLL_RST_CYCLES count.
- rst_n has priority over everything.
- Transient lock loss (a 1-cycle low on pll_locked) in RUN counts as loss. No filtering is applied after release.

Optional Feature:
PLL_RELOCK_CNT_EN
- When defined: adds output relock_cnt [15:0]. It increments, saturating at 16'hFFFF, on each RUN->RESET_PLL transition caused by lock loss (force_relock excluded). It clears only on rst_n=0.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
Parameters for all scenarios unless stated: PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=64, STAGGER=2, MAX_RETRIES=3.
- Clean power-up: rst_n low 3 cycles, then pll_locked=1 from 10 cycles after rst_n rises.
  - pll_rst high exactly 4 cycles.
  - dom_rst goes 111->110->100->000 at 2-cycle spacing, starting 8 cycles after lock_s rises.
  - ready=1 two cycles after dom_rst=000; retries=0, fail=0.
- Lock bounce: pll_locked high 5 cycles, low 1 cycle, then high.
  - Returns to WAIT_LOCK and dom_rst stays 111.
  - Stable window restarts; release begins 8 cycles after the second rising edge of lock_s.
- Never locks: pll_locked=0 permanently.
  - Three RESET_PLL pulses of 4 cycles each, with retries counting 1, 2, 3.
  - fail=1 after the third 64-cycle timeout; pll_rst=0; dom_rst=111 held indefinitely.
- Recovery from FAIL: in FAIL, pulse force_relock with pll_locked=1.
  - fail=0 and retries=0 on the next cycle; pll_rst pulses for 4 cycles.
  - Normal release follows and ready=1.
- Lock loss in RUN: drop pll_locked for 1 cycle.
  - ready=0 and dom_rst=111 three cycles later (2 sync + 1 registered).
  - Full sequence reruns. With PLL_RELOCK_CNT_EN, relock_cnt goes 0->1.
- Simultaneous events: force_relock=1 in the same cycle lock_s falls during RELEASE.
  - RESET_PLL is entered; relock_cnt is unchanged.
  - Mid-sequence rst_n=0 restores all reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Brings the system PLL out of reset, qualifies its lock flag and
//            releases the per-domain resets in a staggered order, with lock
//            loss recovery, timeout retries and a sticky failure flag.
//            Optional feature macro: PLL_RELOCK_CNT_EN (adds relock_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STAGGER        = 8,
    parameter int MAX_RETRIES    = 4,
    parameter int NUM_DOM        = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic [NUM_DOM-1:0] dom_rst,
    output logic               ready,
    output logic               fail,
    output logic [2:0]         retries
`ifdef PLL_RELOCK_CNT_EN
    ,
    output logic [15:0]        relock_cnt
`endif
);

    localparam int c_REL_LEN = NUM_DOM * STAGGER;
    localparam int c_MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
    localparam int c_MAX_B   = (LOCK_TIMEOUT > c_REL_LEN) ? LOCK_TIMEOUT : c_REL_LEN;
    localparam int c_MAX     = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(LOCK_STABLE - 1);
    localparam logic [c_CNT_W-1:0] c_REL_LAST = c_CNT_W'(c_REL_LEN - 1);
    localparam logic [2:0]         c_MAX_RTY  = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           r_retries;
    logic [2:0]           w_retries_nxt;
    logic [2:0]           w_retries_inc;
    logic                 r_sync1;
    logic                 r_lock_s;
    logic                 r_pll_rst;
    logic [NUM_DOM-1:0]   r_dom_rst;
    logic                 r_ready;
    logic                 r_fail;
    logic                 w_pll_rst_nxt;
    logic [NUM_DOM-1:0]   w_dom_rst_nxt;
    logic                 w_ready_nxt;
    logic                 w_fail_nxt;
    logic                 w_lock_loss;

    assign w_retries_inc = r_retries + 3'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_retries_nxt = r_retries;
        w_lock_loss   = 1'b0;
        w_cnt_nxt     = '0;
        w_pll_rst_nxt = 1'b0;
        w_dom_rst_nxt = '1;
        w_ready_nxt   = 1'b0;
        w_fail_nxt    = 1'b0;

        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == c_RST_LAST) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_retries_nxt = w_retries_inc;
                    w_state_nxt   = (w_retries_inc == c_MAX_RTY) ? S_FAIL : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!r_lock_s)                w_state_nxt = S_WAIT_LOCK;
                else if (r_cnt == c_STB_LAST) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!r_lock_s)                w_state_nxt = S_RESET_PLL;
                else if (r_cnt == c_REL_LAST) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_RESET_PLL;
                    w_lock_loss = 1'b1;
                end
            end
            S_FAIL:  w_state_nxt = S_FAIL;
            default: w_state_nxt = S_RESET_PLL;
        endcase

        // A relock request overrides every other event seen in this cycle.
        if (force_relock) begin
            w_state_nxt = S_RESET_PLL;
            w_lock_loss = 1'b0;
            if (r_state != S_RESET_PLL) w_retries_nxt = '0;
        end

        if (force_relock || (w_state_nxt != r_state))
            w_cnt_nxt = '0;
        else if ((r_state == S_RUN) || (r_state == S_FAIL))
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + c_CNT_ONE;

        if (w_state_nxt == S_RUN) w_retries_nxt = '0;

        // Outputs are derived from the next state so they change on entry.
        w_pll_rst_nxt = (w_state_nxt == S_RESET_PLL);
        w_ready_nxt   = (w_state_nxt == S_RUN);
        w_fail_nxt    = (w_state_nxt == S_FAIL);
        if (w_state_nxt == S_RUN) begin
            w_dom_rst_nxt = '0;
        end else if (w_state_nxt == S_RELEASE) begin
            for (int i = 0; i < NUM_DOM; i++)
                w_dom_rst_nxt[i] = (int'(w_cnt_nxt) < i * STAGGER);
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_lock_s  <= 1'b0;
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_retries <= '0;
            r_pll_rst <= 1'b1;
            r_dom_rst <= '1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_sync1   <= pll_locked;
            r_lock_s  <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retries <= w_retries_nxt;
            r_pll_rst <= w_pll_rst_nxt;
            r_dom_rst <= w_dom_rst_nxt;
            r_ready   <= w_ready_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

`ifdef PLL_RELOCK_CNT_EN
    logic [15:0] r_relock_cnt;

    always_ff @(posedge refclk) begin
        if (!rst_n)
            r_relock_cnt <= '0;
        else if (w_lock_loss && (r_relock_cnt != 16'hFFFF))
            r_relock_cnt <= r_relock_cnt + 16'd1;
    end

    assign relock_cnt = r_relock_cnt;
`endif

    assign pll_rst = r_pll_rst;
    assign dom_rst = r_dom_rst;
    assign ready   = r_ready;
    assign fail    = r_fail;
    assign retries = r_retries;

endmodule
`default_nettype wire
